// File: rtl/chacha_arb_pkg.sv
// Shared widths, FSM encodings and the latched job record for the ChaCha20 core arbiter.
package chacha_arb_pkg;

    localparam int KEY_W   = 256;
    localparam int NONCE_W = 96;
    localparam int CTR_W   = 32;
    localparam int BLK_W   = 512;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] GRANT  = 3'd1;
    localparam logic [2:0] LAUNCH = 3'd2;
    localparam logic [2:0] WAIT   = 3'd3;
    localparam logic [2:0] RESP   = 3'd4;

    typedef struct packed {
        logic [KEY_W-1:0]   key;
        logic [NONCE_W-1:0] nonce;
        logic [CTR_W-1:0]   counter;
        logic [BLK_W-1:0]   plaintext;
    } job_t;

endpackage

// File: rtl/chacha_core_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr, wrapping modulo NUM_REQ.
module rr_pick
    import chacha_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   g,
    output logic               any
);

    int idx;

    // Walk from the farthest candidate back to ptr so the last hit wins as the nearest one.
    always_comb begin
        g   = '0;
        any = 1'b0;
        idx = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req[IDX_W'(idx)]) begin
                g   = IDX_W'(idx);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/chacha_core_arbiter.sv
// Round-robin scheduler sharing one ChaCha20 core among NUM_REQ requesters, with a hang watchdog.
// Define CHACHA_ARB_STATS_EN to add per-requester job counters and a timeout counter.
module chacha_core_arbiter
    import chacha_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ),
    parameter int TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*KEY_W-1:0]   req_key,
    input  logic [NUM_REQ*NONCE_W-1:0] req_nonce,
    input  logic [NUM_REQ*CTR_W-1:0]   req_counter,
    input  logic [NUM_REQ*BLK_W-1:0]   req_plaintext,
    output logic [KEY_W-1:0]           core_key,
    output logic [NONCE_W-1:0]         core_nonce,
    output logic [CTR_W-1:0]           core_counter,
    output logic [BLK_W-1:0]           core_plaintext,
    output logic                       core_start,
    input  logic                       core_done,
    input  logic [BLK_W-1:0]           core_ciphertext,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [IDX_W-1:0]           rsp_id,
    output logic [BLK_W-1:0]           rsp_data,
    output logic                       rsp_err,
    output logic                       busy
`ifdef CHACHA_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]      job_count,
    output logic [15:0]                timeout_count
`endif
);

    localparam int WDOG_W = $clog2(TIMEOUT + 1);

    logic [2:0]               state;
    logic [IDX_W-1:0]         rr_ptr;
    logic [IDX_W-1:0]         grant_idx;
    logic [IDX_W-1:0]         pick_idx;
    logic                     pick_any;
    logic [WDOG_W-1:0]        wdog;
    job_t [NUM_REQ-1:0]       jobs;
    job_t                     job_q;
    logic                     grant_ok;
    logic                     wdog_expire;

    rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .g   (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            jobs[i].key       = req_key[i*KEY_W +: KEY_W];
            jobs[i].nonce     = req_nonce[i*NONCE_W +: NONCE_W];
            jobs[i].counter   = req_counter[i*CTR_W +: CTR_W];
            jobs[i].plaintext = req_plaintext[i*BLK_W +: BLK_W];
        end
    end

    // A requester that withdraws between pick and grant forfeits the slot without moving rr_ptr.
    assign grant_ok    = (state == GRANT) && req_valid[grant_idx];
    assign wdog_expire = (state == WAIT) && !core_done && (wdog == WDOG_W'(TIMEOUT - 1));

    always_comb begin
        req_ready = '0;
        if (grant_ok) req_ready[grant_idx] = 1'b1;
    end

    assign core_key       = job_q.key;
    assign core_nonce     = job_q.nonce;
    assign core_counter   = job_q.counter;
    assign core_plaintext = job_q.plaintext;
    assign core_start     = (state == LAUNCH);
    assign rsp_valid      = (state == RESP);
    assign busy           = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
            wdog      <= '0;
            job_q     <= '0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant_idx <= pick_idx;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (grant_ok) begin
                        job_q  <= jobs[grant_idx];
                        rsp_id <= grant_idx;
                        rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                        state  <= LAUNCH;
                    end else begin
                        state <= IDLE;
                    end
                end
                LAUNCH: begin
                    wdog  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (core_done) begin
                        rsp_data <= core_ciphertext;
                        rsp_err  <= 1'b0;
                        state    <= RESP;
                    end else if (wdog_expire) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                        state    <= RESP;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CHACHA_ARB_STATS_EN
    logic [NUM_REQ-1:0][15:0] job_cnt;
    logic [15:0]              tmo_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            job_cnt <= '0;
            tmo_cnt <= '0;
        end else begin
            if (state == RESP && rsp_ready && !rsp_err && job_cnt[rsp_id] != 16'hFFFF)
                job_cnt[rsp_id] <= job_cnt[rsp_id] + 16'd1;
            if (wdog_expire && tmo_cnt != 16'hFFFF)
                tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

    assign job_count     = job_cnt;
    assign timeout_count = tmo_cnt;
`endif

endmodule
